// File: rtl/leaf_out_port_tx.sv
// leaf_out_port_tx: packetizes user words into BFT packets under credit-based flow control
module leaf_out_port_tx #(
  parameter int PACKET_BITS = 49,
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  input  logic                     cfg_vld,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  input  logic                     credit_vld,
  input  logic [NUM_ADDR_BITS-1:0] credit_inc,
  input  logic                     resend,
  input  logic                     pkt_ack,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft
);
  localparam logic [NUM_ADDR_BITS+1:0] CMAX = {2'b01, {NUM_ADDR_BITS{1'b0}}};
  logic [PAYLOAD_BITS-1:0] mem [2];
  logic wp, rp;
  logic [1:0] cnt;
  logic cfgd;
  logic [NUM_LEAF_BITS-1:0] leaf;
  logic [NUM_PORT_BITS-1:0] port;
  logic [NUM_ADDR_BITS:0] credits;
  logic [NUM_ADDR_BITS-1:0] addr;
  logic out_vld;
  logic [PACKET_BITS-2:0] out_pkt;
  logic push, load;
  logic [NUM_ADDR_BITS+1:0] sum;
  always_comb begin
    ack_interface2user = !cnt[1] && !reset;
    push = vld_user2interface && ack_interface2user;
    load = cfgd && cnt != 2'd0 && credits != '0 && !resend && (!out_vld || pkt_ack);
    sum = {1'b0, credits} + (credit_vld ? {2'b0, credit_inc} : '0) - {{(NUM_ADDR_BITS+1){1'b0}}, load};
    dout_leaf_interface2bft = out_vld && !resend ? {1'b1, out_pkt} : '0;
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din_leaf_user2interface;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      cfgd <= 1'b0;
      leaf <= '0;
      port <= '0;
      credits <= CMAX[NUM_ADDR_BITS:0];
      addr <= '0;
      out_vld <= 1'b0;
      out_pkt <= '0;
    end else begin
      wp <= wp ^ push;
      rp <= rp ^ load;
      cnt <= cnt + {1'b0, push} - {1'b0, load};
      credits <= sum > CMAX ? CMAX[NUM_ADDR_BITS:0] : sum[NUM_ADDR_BITS:0];
      if (cfg_vld) begin
        cfgd <= 1'b1;
        leaf <= cfg_dest_leaf;
        port <= cfg_dest_port;
      end
      if (load) begin
        out_vld <= 1'b1;
        out_pkt <= {leaf, port, addr, mem[rp]};
        addr <= addr + NUM_ADDR_BITS'(1);
      end else if (pkt_ack && !resend)
        out_vld <= 1'b0;
    end
endmodule

// File: tb/tb_leaf_out_port_tx.sv
// tb_leaf_out_port_tx: random and directed stimulus checked against a queue-based packetizer model
module tb_leaf_out_port_tx;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] din = '0;
  logic vld = 1'b0, cfg_vld = 1'b0, credit_vld = 1'b0, resend = 1'b0, pkt_ack = 1'b0;
  logic [4:0] cfg_leaf = '0;
  logic [3:0] cfg_port = '0;
  logic [6:0] credit_inc = '0;
  logic ack;
  logic [48:0] dout;
  int checks = 0, errors = 0, seen = 0;
  logic [31:0] q[$];
  int credits, addr;
  bit cfgd, hv;
  logic [4:0] m_leaf;
  logic [3:0] m_port;
  logic [47:0] held;

  always #5 clk = ~clk;

  leaf_out_port_tx dut (
    .clk(clk), .reset(reset),
    .din_leaf_user2interface(din), .vld_user2interface(vld), .ack_interface2user(ack),
    .cfg_vld(cfg_vld), .cfg_dest_leaf(cfg_leaf), .cfg_dest_port(cfg_port),
    .credit_vld(credit_vld), .credit_inc(credit_inc),
    .resend(resend), .pkt_ack(pkt_ack), .dout_leaf_interface2bft(dout)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [48:0] pk(logic [4:0] l, logic [3:0] p, int a, logic [31:0] w);
    return {1'b1, l, p, a[6:0], w};
  endfunction

  task automatic model_reset();
    q.delete();
    credits = 128;
    addr = 0;
    cfgd = 0;
    hv = 0;
    m_leaf = '0;
    m_port = '0;
    held = '0;
  endtask

  // Called at a negedge with inputs already driven; checks, advances the model, returns at next negedge.
  task automatic cycle();
    bit ld, acc;
    logic [48:0] ed;
    #1;
    ed = hv && !resend ? {1'b1, held} : '0;
    check("ack", 64'(ack), 64'(q.size() < 2));
    check("dout", 64'(dout), 64'(ed));
    if (dout[48]) seen++;
    ld = cfgd && q.size() > 0 && credits > 0 && !resend && (!hv || pkt_ack);
    acc = vld && q.size() < 2;
    if (ld) begin
      held = {m_leaf, m_port, 7'(addr), q.pop_front()};
      hv = 1;
      addr = (addr + 1) % 128;
    end else if (pkt_ack && !resend) hv = 0;
    credits = credits + (credit_vld ? int'(credit_inc) : 0) - int'(ld);
    if (credits > 128) credits = 128;
    if (acc) q.push_back(din);
    if (cfg_vld) begin
      cfgd = 1;
      m_leaf = cfg_leaf;
      m_port = cfg_port;
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_dout", 64'(dout), 64'(0));
    model_reset();
    reset = 1'b0;
    // basic: configure, then four words streamed with pkt_ack held
    cfg_vld = 1'b1; cfg_leaf = 5'd3; cfg_port = 4'd2; pkt_ack = 1'b1;
    cycle();
    cfg_vld = 1'b0;
    for (int j = 0; j < 6; j++) begin
      vld = j < 4;
      din = 32'hA5A5_0001 + j;
      if (j >= 2) begin
        #1;
        check("basic", 64'(dout), 64'(pk(5'd3, 4'd2, j - 2, 32'hA5A5_0001 + (j - 2))));
      end
      cycle();
    end
    // credit exhaustion: top credits back to full, then stream 140 words with no returns
    vld = 1'b0; credit_vld = 1'b1; credit_inc = 7'd64;
    cycle();
    credit_vld = 1'b0;
    seen = 0;
    for (int j = 0; j < 140; j++) begin
      vld = 1'b1;
      din = $urandom;
      cycle();
    end
    vld = 1'b0;
    for (int j = 0; j < 5; j++) cycle();
    check("exhaust_pkts", 64'(seen), 64'(128));
    seen = 0;
    credit_vld = 1'b1; credit_inc = 7'd64;
    cycle();
    credit_vld = 1'b0;
    for (int j = 0; j < 4; j++) cycle();
    check("refill_pkts", 64'(seen), 64'(2));
    // backpressure then resend
    pkt_ack = 1'b0; vld = 1'b1;
    for (int j = 0; j < 5; j++) begin
      din = $urandom;
      cycle();
    end
    vld = 1'b0; resend = 1'b1; pkt_ack = 1'b1;
    for (int j = 0; j < 2; j++) cycle();
    resend = 1'b0; pkt_ack = 1'b0;
    cycle();
    pkt_ack = 1'b1;
    for (int j = 0; j < 4; j++) cycle();
    // random mix
    for (int j = 0; j < 1500; j++) begin
      vld = $urandom_range(0, 9) < 7;
      din = $urandom;
      pkt_ack = $urandom_range(0, 9) < 7;
      resend = $urandom_range(0, 9) == 0;
      credit_vld = $urandom_range(0, 9) == 0;
      credit_inc = 7'($urandom_range(1, 64));
      cfg_vld = $urandom_range(0, 49) == 0;
      cfg_leaf = 5'($urandom);
      cfg_port = 4'($urandom);
      cycle();
    end
    // reset while a packet is held
    cfg_vld = 1'b0; resend = 1'b0; pkt_ack = 1'b0; vld = 1'b1;
    credit_vld = 1'b1; credit_inc = 7'd64;
    for (int j = 0; j < 3; j++) cycle();
    check("pre_rst_vld", 64'(dout[48]), 64'(1));
    credit_vld = 1'b0; vld = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_dout", 64'(dout), 64'(0));
    check("midrst_ack", 64'(ack), 64'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    // unconfigured after reset: words fill FIFO but nothing issues
    pkt_ack = 1'b1; vld = 1'b1;
    for (int j = 0; j < 4; j++) begin
      din = 32'hC0DE_0000 + j;
      cycle();
    end
    check("unconf_ack", 64'(ack), 64'(0));
    vld = 1'b0; cfg_vld = 1'b1; cfg_leaf = 5'd9; cfg_port = 4'd5;
    seen = 0;
    cycle();
    cfg_vld = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j == 1) begin
        #1;
        check("post_cfg_first", 64'(dout), 64'(pk(5'd9, 4'd5, 0, 32'hC0DE_0000)));
      end
      cycle();
    end
    check("post_cfg_pkts", 64'(seen), 64'(2));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
